// File: rtl/sdi_byte_packer_if.sv
// Byte-in / word-out handshake bundle for sdi_byte_packer.
//   master : producer + consumer side (drives bytes, flush, out_ready)
//   slave  : the packer itself
// Signals: in_data/in_valid/in_ready (byte push), flush (tail drain request),
//          out_data/out_valid/out_ready/out_last (word pop), level (bytes held).
interface sdi_byte_packer_if #(
    parameter int unsigned BUSW  = 32,
    parameter int unsigned DEPTH = 64
);
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         flush;
    logic [BUSW-1:0]              out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_last, level
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_last, level
    );
endinterface

// File: rtl/sdi_byte_packer.sv
// Byte-to-word packing FIFO for a BUSW-wide valid/ready SDI/PDI port.
// Bytes enter one per cycle into a DEPTH-byte circular store and leave as
// BUSW-bit words, first-written byte in the top byte lane.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (buffer contents are not cleared)
//   bus  : sdi_byte_packer_if.slave (byte push, word pop, flush, level)
//
// Build option: define BYTE_PACKER_FLUSH_EN to enable the flush path (DRAIN
// state, zero-padded tail word, out_last). Without it, flush is ignored and
// partial words wait for more bytes.
module sdi_byte_packer #(
    parameter int unsigned BUSW  = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    sdi_byte_packer_if.slave   bus
);
    localparam int unsigned W  = BUSW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] popped;
    logic          flush_pend;
    logic          tail;
    logic          push, pop;
    logic          out_valid;

    // Ready depends on registered state only; no path from out_ready.
    assign bus.in_ready = (level_q < LW'(DEPTH)) && !flush_pend;
    assign out_valid    = (level_q >= LW'(W)) || (flush_pend && (level_q != '0));
    assign bus.out_valid = out_valid;
    assign bus.level     = level_q;

    assign tail   = flush_pend && (level_q < LW'(W));
    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = out_valid && bus.out_ready;
    // A tail word drains everything left; otherwise exactly one word.
    assign popped = tail ? level_q : LW'(W);

    always_comb begin
        level_d = level_q + LW'(push);
        if (pop) begin
            level_d = level_d - popped;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < int'(W); k++) begin
            logic [PW-1:0] idx;
            logic [7:0]    b;
            idx = rp_q + PW'(k);
            b   = mem[idx];
            // Pad bytes past the stored count in a tail word.
            if (tail && (LW'(k) >= level_q)) begin
                b = 8'h00;
            end
            bus.out_data[BUSW-1-8*k -: 8] = b;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + PW'(popped);
            end
            level_q <= level_d;
        end
    end

`ifdef BYTE_PACKER_FLUSH_EN
    typedef enum logic [0:0] {StIdle, StDrain} state_e;
    state_e state_q;

    // Leaves DRAIN as soon as the store will be empty after this edge,
    // which also covers entering with nothing stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.flush) state_q <= StDrain;
                StDrain: if (level_d == '0) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign flush_pend   = (state_q == StDrain);
    assign bus.out_last = flush_pend && out_valid && (level_q <= LW'(W));
`else
    logic unused_flush;
    assign unused_flush = bus.flush;
    assign flush_pend   = 1'b0;
    assign bus.out_last = 1'b0;
`endif
endmodule

// File: tb/tb_sdi_byte_packer.sv
module tb_sdi_byte_packer;
    localparam int unsigned BUSW  = 32;
    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lvl_m  = 0;
    exp_t exp_q[$];
    logic [7:0] acc_q[$];

    sdi_byte_packer_if #(.BUSW(BUSW), .DEPTH(DEPTH)) bus ();

    sdi_byte_packer #(.BUSW(BUSW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data", 64'(bus.out_data), 64'(e.data));
                chk("word_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic with a simple occupancy model; called #1 after an edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit ordy);
        bit acc, pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        acc = v && (lvl_m < DEPTH);
        pop = ordy && (lvl_m >= 4);
        chk("level", 64'(bus.level), 64'(lvl_m));
        chk("in_ready", 64'(bus.in_ready), 64'(lvl_m < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(lvl_m >= 4));
        step();
        if (acc) begin
            acc_q.push_back(d);
            if (acc_q.size() == 4) begin
                exp_q.push_back('{data: {acc_q[0], acc_q[1], acc_q[2], acc_q[3]}, last: 1'b0});
                acc_q.delete();
            end
        end
        lvl_m = lvl_m + int'(acc) - (pop ? 4 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        int nb;
        int guard;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_level", 64'(bus.level), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_last", 64'(bus.out_last), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 1);
        rst = 1'b0;

        // Basic packing, out_valid one cycle after each 4th byte.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Fill to capacity with the consumer stalled.
        n_acc = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.in_ready) n_acc++;
            cycle(1'b1, 8'(8'h40 + i), 1'b0);
        end
        chk("fill_accepted", 64'(n_acc), 64);
        chk("fill_level", 64'(bus.level), 64);
        chk("fill_in_ready", 64'(bus.in_ready), 0);

        // Drain while pushing: pointers wrap, push and pop overlap.
        nb = 8'h80;
        guard = 0;
        while (nb < 8'h80 + 32 && guard < 200) begin
            logic a;
            a = (lvl_m < DEPTH);
            cycle(1'b1, 8'(nb), 1'b1);
            if (a) nb++;
            guard++;
        end
        chk("wrap_bound", 64'(guard < 200), 1);
        guard = 0;
        while (lvl_m >= 4 && guard < 100) begin
            cycle(1'b0, 8'h00, 1'b1);
            guard++;
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_empty", 64'(bus.level), 0);
        chk("wrap_scoreboard", 64'(exp_q.size()), 0);

        // Reset mid-stream with 17 bytes held.
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_level", 64'(bus.level), 17);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_level", 64'(bus.level), 0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 1);
        exp_q.delete();
        acc_q.delete();
        lvl_m = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

`ifdef BYTE_PACKER_FLUSH_EN
        // Flush with 5 bytes: one full word, then a padded tail.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        acc_q.delete();
        exp_q.push_back('{data: 32'h1400_0000, last: 1'b1});
        chk("fl5_in_ready", 64'(bus.in_ready), 0);
        chk("fl5_out_valid", 64'(bus.out_valid), 1);
        chk("fl5_out_last0", 64'(bus.out_last), 0);
        bus.out_ready = 1'b1;
        step();
        chk("fl5_level1", 64'(bus.level), 1);
        chk("fl5_out_last1", 64'(bus.out_last), 1);
        chk("fl5_in_ready1", 64'(bus.in_ready), 0);
        step();
        chk("fl5_level0", 64'(bus.level), 0);
        chk("fl5_out_valid0", 64'(bus.out_valid), 0);
        chk("fl5_idle", 64'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        lvl_m = 0;

        // Flush with exactly two full words.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        exp_q[exp_q.size() - 1].last = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl8_out_last0", 64'(bus.out_last), 0);
        bus.out_ready = 1'b1;
        step();
        chk("fl8_level", 64'(bus.level), 4);
        chk("fl8_out_last1", 64'(bus.out_last), 1);
        step();
        chk("fl8_level0", 64'(bus.level), 0);
        chk("fl8_idle", 64'(bus.in_ready), 1);
        lvl_m = 0;

        // Flush with nothing stored.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl0_drain", 64'(bus.in_ready), 0);
        chk("fl0_out_valid", 64'(bus.out_valid), 0);
        step();
        chk("fl0_idle", 64'(bus.in_ready), 1);
`else
        // Flush is ignored: the partial word stays until completed.
        cycle(1'b1, 8'h30, 1'b1);
        cycle(1'b1, 8'h31, 1'b1);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        chk("nofl_out_valid", 64'(bus.out_valid), 0);
        chk("nofl_in_ready", 64'(bus.in_ready), 1);
        chk("nofl_level", 64'(bus.level), 2);
        cycle(1'b1, 8'h32, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
`endif
        cycle(1'b0, 8'h00, 1'b1);
        chk("end_scoreboard", 64'(exp_q.size()), 0);
        chk("end_level", 64'(bus.level), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
